// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, FSM states,
// PC source selects and the decoded instruction-class bundle.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_IMM = 2'd1;
  localparam logic [1:0] PCSRC_REG = 2'd2;

  typedef struct packed {
    logic is_alu;
    logic is_shift;
    logic is_lw;
    logic is_sw;
    logic is_llb;
    logic is_lhb;
    logic is_b;
    logic is_br;
    logic is_pcs;
    logic is_hlt;
    logic is_illegal;
  } op_class_t;

  // Classes that finish in EXEC without touching memory.
  function automatic logic retires_in_exec(op_class_t c);
    return c.is_alu | c.is_llb | c.is_lhb | c.is_pcs | c.is_b | c.is_br;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Unified memory port between the control sequencer (master) and memory (slave).
// A request stays up until mem_ready completes it.
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; any set bit above [3:0] makes the opcode illegal.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] op_i,
  output op_class_t           cls_o
);

  logic upper_nz;

  generate
    if (OPCODE_W > 4) begin : g_upper
      assign upper_nz = |op_i[OPCODE_W-1:4];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    cls_o = '0;
    if (upper_nz) begin
      cls_o.is_illegal = 1'b1;
    end else begin
      case (op_i[3:0])
        OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: cls_o.is_alu = 1'b1;
        OP_SLL, OP_SRA, OP_ROR: begin
          cls_o.is_alu   = 1'b1;
          cls_o.is_shift = 1'b1;
        end
        OP_LW:  cls_o.is_lw  = 1'b1;
        OP_SW:  cls_o.is_sw  = 1'b1;
        OP_LLB: cls_o.is_llb = 1'b1;
        OP_LHB: cls_o.is_lhb = 1'b1;
        OP_B:   cls_o.is_b   = 1'b1;
        OP_BR:  cls_o.is_br  = 1'b1;
        OP_PCS: cls_o.is_pcs = 1'b1;
        OP_HLT: cls_o.is_hlt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer over a shared memory port, with
// illegal-opcode and bus-timeout traps, sticky halt and a saturating retire counter.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_fsm_if.master mem,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 branch_taken,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src,
  output logic                 dst_reg,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 load_higher,
  output logic                 load_lower,
  output logic                 pcs,
  output logic                 halted,
  output logic                 illegal_op,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     retired
);

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;

  logic                mem_phase;
  logic                timeout;
  logic                retire;
  logic [OPCODE_W-1:0] dec_op;
  op_class_t           cls;

  // DECODE classifies the live IR field; later states only see the captured copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : opcode_q;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .op_i  (dec_op),
    .cls_o (cls)
  );

  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout   = (WAIT_MAX != 0) && mem_phase && !mem.mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        opcode_d = opcode;
        if (cls.is_illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else if (cls.is_hlt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.is_lw || cls.is_sw) begin
          state_d = S_MEM;
        end else if (retires_in_exec(cls)) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          if (cls.is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Counts consecutive unanswered request cycles within one state visit.
    if ((WAIT_MAX != 0) && mem_phase && !mem.mem_ready && (state_d == state_q)) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = '0;
    end

    if (retire && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  logic mem_req_c, mem_we_c, addr_sel_c;

  // Gating with rst_n drops an in-flight request the moment reset asserts.
  always_comb begin
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_sel_c  = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PCSRC_SEQ;
    alu_src     = 1'b0;
    dst_reg     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    load_higher = 1'b0;
    load_lower  = 1'b0;
    pcs         = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req_c = 1'b1;
          ir_load   = mem.mem_ready;
          pc_write  = mem.mem_ready;
          pc_src    = PCSRC_SEQ;
        end
        S_EXEC: begin
          if (cls.is_alu) begin
            reg_write = 1'b1;
            dst_reg   = 1'b1;
            alu_src   = cls.is_shift;
          end
          if (cls.is_llb || cls.is_lhb) begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            load_lower  = cls.is_llb;
            load_higher = cls.is_lhb;
          end
          if (cls.is_pcs) begin
            reg_write = 1'b1;
            pcs       = 1'b1;
          end
          if (cls.is_b || cls.is_br) begin
            pc_write = branch_taken;
            pc_src   = cls.is_br ? PCSRC_REG : PCSRC_IMM;
          end
          if (cls.is_lw || cls.is_sw) begin
            alu_src = 1'b1;
          end
        end
        S_MEM: begin
          mem_req_c  = 1'b1;
          addr_sel_c = 1'b1;
          alu_src    = 1'b1;
          mem_we_c   = cls.is_sw;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_we   = mem_we_c;
  assign mem.addr_sel = addr_sel_c;

  assign halted     = (state_q == S_HALT);
  assign illegal_op = illegal_q;
  assign bus_err    = bus_err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench: an instruction-level model expands each instruction into its
// expected per-cycle output vectors, which are replayed against the DUT.
module tb_multicycle_ctrl_fsm;

  localparam int OPW     = 6;
  localparam int WMAX    = 4;
  localparam int CW      = 2;
  localparam int RET_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [OPW-1:0] opcode = '0;
  logic           branch_taken = 1'b0;
  logic           ir_load, pc_write, alu_src, dst_reg, reg_write, mem_to_reg;
  logic           load_higher, load_lower, pcs, halted, illegal_op, bus_err;
  logic [1:0]     pc_src;
  logic [CW-1:0]  retired;

  multicycle_ctrl_fsm_if mem_if();

  multicycle_ctrl_fsm #(.OPCODE_W(OPW), .WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mem_if),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src      (alu_src),
    .dst_reg      (dst_reg),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .load_higher  (load_higher),
    .load_lower   (load_lower),
    .pcs          (pcs),
    .halted       (halted),
    .illegal_op   (illegal_op),
    .bus_err      (bus_err),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mem_req, mem_we, addr_sel, ir_load, pc_write;
    logic [1:0]    pc_src;
    logic          alu_src, dst_reg, reg_write, mem_to_reg, load_higher, load_lower, pcs;
    logic          halted, illegal_op, bus_err;
    logic [CW-1:0] retired;
  } obs_t;

  typedef struct {
    logic [OPW-1:0] op;
    logic           taken;
    logic           rdy;
    obs_t           exp;
  } cyc_t;

  cyc_t q[$];
  int   n_ret = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  function automatic obs_t sample();
    obs_t o;
    o.mem_req = mem_if.mem_req;  o.mem_we = mem_if.mem_we;  o.addr_sel = mem_if.addr_sel;
    o.ir_load = ir_load;  o.pc_write = pc_write;  o.pc_src = pc_src;
    o.alu_src = alu_src;  o.dst_reg = dst_reg;  o.reg_write = reg_write;
    o.mem_to_reg = mem_to_reg;  o.load_higher = load_higher;  o.load_lower = load_lower;
    o.pcs = pcs;  o.halted = halted;  o.illegal_op = illegal_op;  o.bus_err = bus_err;
    o.retired = retired;
    return o;
  endfunction

  function automatic obs_t idle();
    obs_t o = '0;
    o.retired = CW'((n_ret > RET_MAX) ? RET_MAX : n_ret);
    return o;
  endfunction

  function automatic void push(logic [OPW-1:0] op, logic tk, logic rdy, obs_t e);
    cyc_t c;
    c.op = op;  c.taken = tk;  c.rdy = rdy;  c.exp = e;
    q.push_back(c);
  endfunction

  function automatic void halt_seq(logic [OPW-1:0] op, logic tk, logic ill, logic berr, int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = idle();  e.halted = 1'b1;  e.illegal_op = ill;  e.bus_err = berr;
      push(op, tk, 1'b1, e);
    end
  endfunction

  // Expands one instruction: fw/mw are memory wait states in FETCH/MEM.
  function automatic void instr(int op, logic tk, int fw, int mw, int nhalt);
    obs_t e;
    logic [OPW-1:0] o = OPW'(op);
    for (int i = 0; i < fw && i < WMAX; i++) begin
      e = idle();  e.mem_req = 1'b1;
      push(o, tk, 1'b0, e);
    end
    if (fw >= WMAX) begin halt_seq(o, tk, 1'b0, 1'b1, nhalt); return; end
    e = idle();  e.mem_req = 1'b1;  e.ir_load = 1'b1;  e.pc_write = 1'b1;
    push(o, tk, 1'b1, e);
    push(o, tk, 1'b1, idle());
    if (op == 15) begin halt_seq(o, tk, 1'b0, 1'b0, nhalt); return; end
    if (op > 15)  begin halt_seq(o, tk, 1'b1, 1'b0, nhalt); return; end
    e = idle();
    case (op)
      0, 1, 2, 3, 7: begin e.reg_write = 1'b1; e.dst_reg = 1'b1; end
      4, 5, 6:       begin e.reg_write = 1'b1; e.dst_reg = 1'b1; e.alu_src = 1'b1; end
      8, 9:          e.alu_src = 1'b1;
      10:            begin e.reg_write = 1'b1; e.alu_src = 1'b1; e.load_lower = 1'b1; end
      11:            begin e.reg_write = 1'b1; e.alu_src = 1'b1; e.load_higher = 1'b1; end
      12:            begin e.pc_write = tk; e.pc_src = 2'd1; end
      13:            begin e.pc_write = tk; e.pc_src = 2'd2; end
      14:            begin e.reg_write = 1'b1; e.pcs = 1'b1; end
      default: ;
    endcase
    push(o, tk, 1'b1, e);
    if (op != 8 && op != 9) begin n_ret++; return; end
    for (int i = 0; i < mw && i < WMAX; i++) begin
      e = idle();  e.mem_req = 1'b1;  e.addr_sel = 1'b1;  e.alu_src = 1'b1;  e.mem_we = (op == 9);
      push(o, tk, 1'b0, e);
    end
    if (mw >= WMAX) begin halt_seq(o, tk, 1'b0, 1'b1, nhalt); return; end
    e = idle();  e.mem_req = 1'b1;  e.addr_sel = 1'b1;  e.alu_src = 1'b1;  e.mem_we = (op == 9);
    push(o, tk, 1'b1, e);
    if (op == 9) begin n_ret++; return; end
    e = idle();  e.reg_write = 1'b1;  e.mem_to_reg = 1'b1;
    push(o, tk, 1'b1, e);
    n_ret++;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Entered and left just after a rising edge.
  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode = c.op;  branch_taken = c.taken;  mem_if.mem_ready = c.rdy;
      @(negedge clk);
      chk($sformatf("cycle %0d outputs", cyc), 32'(sample()), 32'(c.exp));
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;  opcode = '0;  branch_taken = 1'b0;  mem_if.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'(sample()), 32'h0);
    rst_n = 1'b1;
    n_ret = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t e;
    mem_if.mem_ready = 1'b0;
    do_reset();

    instr(0, 1'b0, 0, 0, 0);
    chk("ADD length", 32'(q.size()), 32'd3);
    play();
    chk("retired after ADD", 32'(retired), 32'd1);

    instr(8, 1'b0, 0, 2, 0);
    chk("LW 2-wait length", 32'(q.size()), 32'd7);
    play();
    instr(9, 1'b0, 0, 0, 0);
    chk("SW length", 32'(q.size()), 32'd4);
    play();

    instr(12, 1'b1, 0, 0, 0);  instr(12, 1'b0, 0, 0, 0);  instr(13, 1'b1, 0, 0, 0);
    instr(1, 1'b0, 0, 0, 0);   instr(4, 1'b0, 0, 0, 0);   instr(5, 1'b0, 0, 0, 0);
    instr(6, 1'b0, 0, 0, 0);   instr(2, 1'b0, 0, 0, 0);   instr(10, 1'b0, 0, 0, 0);
    instr(11, 1'b0, 0, 0, 0);  instr(14, 1'b0, 0, 0, 0);  instr(7, 1'b0, 0, 0, 0);
    instr(8, 1'b0, 0, 0, 0);
    play();
    chk("retired saturated", 32'(retired), 32'd3);

    instr(0, 1'b0, 3, 0, 0);  instr(3, 1'b0, 3, 0, 0);  instr(8, 1'b0, 3, 3, 0);
    play();
    chk("no bus_err at last wait", 32'(bus_err), 32'd0);

    // Partial LW: leave the DUT waiting in MEM, then reset under it.
    e = idle();  e.mem_req = 1'b1;  e.ir_load = 1'b1;  e.pc_write = 1'b1;
    push(6'd8, 1'b0, 1'b1, e);
    push(6'd8, 1'b0, 1'b1, idle());
    e = idle();  e.alu_src = 1'b1;
    push(6'd8, 1'b0, 1'b1, e);
    e = idle();  e.mem_req = 1'b1;  e.addr_sel = 1'b1;  e.alu_src = 1'b1;
    push(6'd8, 1'b0, 1'b0, e);
    play();
    mem_if.mem_ready = 1'b0;
    #2;
    chk("mid-MEM mem_req", 32'(mem_if.mem_req), 32'd1);
    chk("mid-MEM addr_sel", 32'(mem_if.addr_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset drops outputs", 32'(sample()), 32'h0);
    do_reset();

    instr(0, 1'b0, 0, 0, 0);
    play();
    chk("retired restarts", 32'(retired), 32'd1);

    instr(15, 1'b0, 0, 0, 5);
    play();
    chk("HLT halted", 32'(halted), 32'd1);
    chk("HLT not retired", 32'(retired), 32'd1);
    chk("HLT not illegal", 32'(illegal_op), 32'd0);

    do_reset();
    instr(19, 1'b0, 0, 0, 20);
    play();
    chk("illegal_op sticky", 32'(illegal_op), 32'd1);

    do_reset();
    instr(0, 1'b0, 10, 0, 5);
    play();
    chk("fetch timeout bus_err", 32'(bus_err), 32'd1);

    do_reset();
    instr(9, 1'b0, 0, 10, 5);
    play();
    chk("MEM timeout bus_err", 32'(bus_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle successor to the single-cycle control decoder. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory with a req/ready handshake. It is parametrised in opcode width and memory-wait timeout. It adds illegal-opcode trapping, bus-timeout trapping, a sticky halt and a retired-instruction counter. It sits between the IR/PC datapath and the unified memory port.

Parameters:
OPCODE_W, 4, opcode field width (>=4); any nonzero bit above [3:0] marks the opcode illegal
WAIT_MAX, 16, max cycles of mem_req without mem_ready before bus error; 0 disables timeout
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  opcode field from IR; valid from DECODE onward
branch_taken  in  1  condition-flag check result for the current B/BR
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write enable; valid with mem_req
addr_sel  out  1  0 = PC address, 1 = ALU address
ir_load  out  1  capture memory read data into IR
pc_write  out  1  update PC
pc_src  out  2  0 = PC+2, 1 = PC+imm, 2 = register
alu_src  out  1  ALU B operand is immediate
dst_reg  out  1  destination register field select
reg_write  out  1  register file write
mem_to_reg  out  1  writeback data from memory
load_higher  out  1  LHB writeback
load_lower  out  1  LLB writeback
pcs  out  1  writeback of PC+2
halted  out  1  sticky halt
illegal_op  out  1  sticky, set with halt on illegal opcode
bus_err  out  1  sticky, set with halt on memory timeout
retired  out  CNT_W  count of completed instructions, saturating

Behaviour:
- Reset (async, rst_n=0): state=FETCH; wait counter=0; retired=0; halted/illegal_op/bus_err=0; opcode register=0. All control outputs are 0 during reset.
- Opcode map: 0000–0111 ALU (ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB), 1000 LW, 1001 SW, 1010 LLB, 1011 LHB, 1100 B, 1101 BR, 1110 PCS, 1111 HLT.
- Opcode handling: opcode is registered at DECODE. EXEC/MEM/WB decode from the registered copy only.
- Output decode: all outputs are Moore decodes of state plus the registered opcode, except ir_load and pc_write in FETCH, which are gated by mem_ready (Mealy).
- FETCH: mem_req=1, mem_we=0, addr_sel=0. On mem_ready: ir_load=1, pc_write=1, pc_src=0, next=DECODE. Otherwise remain.
- DECODE (1 cycle):
  - HLT -> HALT.
  - Illegal -> HALT with illegal_op=1.
  - Else -> EXEC.
- EXEC (1 cycle):
  - ALU: reg_write=1, dst_reg=1; alu_src=1 for SLL/SRA/ROR. Retire, -> FETCH.
  - LLB/LHB: reg_write=1, alu_src=1, load_lower/load_higher. Retire, -> FETCH.
  - PCS: reg_write=1, pcs=1. Retire, -> FETCH.
  - B/BR: pc_write=branch_taken; pc_src=1 (B) or 2 (BR). Retire, -> FETCH.
  - LW/SW: alu_src=1, -> MEM.
- MEM: mem_req=1, addr_sel=1, alu_src=1, mem_we=(SW). On mem_ready: SW retires -> FETCH; LW -> WB.
- WB: reg_write=1, mem_to_reg=1. Retire, -> FETCH.
- Latency with zero wait states: ALU/LLB/LHB/PCS/B/BR 3 cycles; SW 4; LW 5. Each wait state adds 1.
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0.
  - Clears on mem_ready or on state change.
  - If WAIT_MAX>0 and the counter reaches WAIT_MAX-1 while mem_ready=0: next=HALT, bus_err=1.
  - mem_ready in that same cycle wins (normal completion).
- HALT: all control outputs 0, halted=1. Exit only via reset. HLT does not increment retired.
- retired: increments in the retiring cycle; holds at 2^CNT_W-1.
- Reset mid-operation: immediate return to FETCH. Any in-flight memory request is dropped (mem_req falls asynchronously).

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_ADD..OP_HLT);
  - state encoding (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT);
  - pc_src encodings (PCSRC_SEQ, PCSRC_IMM, PCSRC_REG).
- Sub-module ctrl_decode (combinational): registered opcode -> instruction-class flags (is_alu, is_shift, is_lw, is_sw, is_llb, is_lhb, is_b, is_br, is_pcs, is_hlt, is_illegal), parametrised by OPCODE_W.
- The FSM, wait counter and retired counter live in the top module.

Test Plan:
- ADD (0000), mem_ready always 1 -> FETCH/DECODE/EXEC in 3 cycles; reg_write=1 only in EXEC; retired 0->1.
- LW (1000), mem_ready delayed 2 cycles in MEM -> MEM held 3 cycles with mem_we=0 and addr_sel=1; WB asserts mem_to_reg=1 and reg_write=1; total 7 cycles.
- B (1100) with branch_taken=1 then 0 -> pc_write=1 with pc_src=1 in EXEC for the first instruction; pc_write=0 in EXEC for the second.
- OPCODE_W=6, opcode 6'b010011 -> HALT after DECODE; illegal_op=1; halted=1; outputs stay 0 for 20 further cycles.
- WAIT_MAX=4, mem_ready held 0 in FETCH -> bus_err and halted on the 5th cycle; also check mem_ready=1 on the 4th cycle completes the fetch normally with no bus_err.
- CNT_W=2 with 5 ALU instructions -> retired saturates at 3; rst_n pulsed low mid-MEM -> outputs 0 immediately; FETCH and retired=0 after release.
